mmu_bus_arb: RTL and testbench

Two-master bus arbiter that shares the physical memory bus behind the rf68851 MMU between the translated CPU port (master 0) and a secondary requester such as the table walker or a DMA engine (master 1). It grants whole bus cycles round-robin and holds a grant for as long as the winner keeps `cyc` asserted. It routes `ack`/`err`/`vpa` back only to the granted master. An optional watchdog terminates stalled cycles with a bus error.

---
 rtl/mmu_bus_arb.sv | 186 ++++++++++++++++++
 tb/tb_mmu_bus_arb.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_bus_arb.sv
// mmu_bus_arb: two-master round-robin arbiter for the physical bus behind
// the MMU. Master 0 is the translated CPU port, master 1 a secondary
// requester (table walker / DMA). A grant is held for as long as the owner
// keeps cyc asserted, so locked read-modify-write sequences stay atomic.
// Slave responses are routed only to the granted master.
//
// Optional feature: define MMU_ARB_WATCHDOG_EN to build a stall watchdog
// that terminates a strobe left unanswered for TIMEOUT cycles with a bus
// error. Without the macro no counter exists and TIMEOUT is ignored.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | no owner, all slave-side outputs driven to 0
// ST_GNT0   | master 0 owns the bus until it drops m0_cyc_i
// ST_GNT1   | master 1 owns the bus until it drops m1_cyc_i

module mmu_bus_arb #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic [2:0]  m0_fc_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_vpa_o,

  input  logic [2:0]  m1_fc_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_vpa_o,

  output logic [2:0]  s_fc_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_vpa_i,

  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  // 0: master 0 was granted most recently, 1: master 1 was.
  logic   last_q;
  logic   wd_fire;
  logic   gnt0, gnt1;

  // Reject out-of-range watchdog limits at elaboration; the counter is 8 bits.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("mmu_bus_arb: TIMEOUT must be within 1..255");
  end

  // State and round-robin pointer; last is loaded on entry to a grant state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_d == ST_GNT0 && state_q != ST_GNT0) begin
        last_q <= 1'b0;
      end else if (state_d == ST_GNT1 && state_q != ST_GNT1) begin
        last_q <= 1'b1;
      end
    end
  end

  // Next-state: hold while the owner keeps cyc, hand over with no dead cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? ST_GNT0 : ST_GNT1;
        end else if (m0_cyc_i) begin
          state_d = ST_GNT0;
        end else if (m1_cyc_i) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT0: begin
        if (!m0_cyc_i) begin
          state_d = m1_cyc_i ? ST_GNT1 : ST_IDLE;
        end
      end
      ST_GNT1: begin
        if (!m1_cyc_i) begin
          state_d = m0_cyc_i ? ST_GNT0 : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign gnt0  = (state_q == ST_GNT0);
  assign gnt1  = (state_q == ST_GNT1);
  assign gnt_o = {gnt1, gnt0};

  // Slave-side mux: the granted master's request, all zero while idle.
  always_comb begin
    s_fc_o  = 3'd0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = 4'd0;
    s_adr_o = 32'd0;
    s_dat_o = 32'd0;
    if (gnt0) begin
      s_fc_o  = m0_fc_i;
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
      s_we_o  = m0_we_i;
      s_sel_o = m0_sel_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
    end else if (gnt1) begin
      s_fc_o  = m1_fc_i;
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
    end
  end

  // Read data is broadcast; only the owner samples it on its ack.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign m0_ack_o = gnt0 & s_ack_i;
  assign m0_vpa_o = gnt0 & s_vpa_i;
  assign m0_err_o = gnt0 & (s_err_i | wd_fire);
  assign m1_ack_o = gnt1 & s_ack_i;
  assign m1_vpa_o = gnt1 & s_vpa_i;
  assign m1_err_o = gnt1 & (s_err_i | wd_fire);

`ifdef MMU_ARB_WATCHDOG_EN
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);

  logic [7:0] wd_cnt_q;

  // The firing cycle clears the counter itself, so the error is one cycle wide.
  assign wd_fire = (wd_cnt_q == WD_LIMIT);

  // Count cycles the granted strobe waits without any slave response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_cnt_q <= 8'd0;
    end else if (state_q == ST_IDLE || !s_stb_o || s_ack_i || s_err_i || wd_fire) begin
      wd_cnt_q <= 8'd0;
    end else begin
      wd_cnt_q <= wd_cnt_q + 8'd1;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

endmodule

// File: tb/tb_mmu_bus_arb.sv
// Bench for mmu_bus_arb: a table of single-cycle vectors, hand-written
// multi-cycle sequences (locked RMW, watchdog, async reset), then random
// traffic checked against a behavioural model of owner/last/stall count.

module tb_mmu_bus_arb;

  localparam int TIMEOUT = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;

  logic [1:0]  cyc, stb, we;
  logic [2:0]  fc   [2];
  logic [3:0]  sel  [2];
  logic [31:0] adr  [2];
  logic [31:0] wdat [2];
  logic [31:0] rdat0, rdat1;
  logic        ack0, err0, vpa0, ack1, err1, vpa1;

  logic [2:0]  s_fc_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i, s_err_i, s_vpa_i;
  logic [1:0]  gnt_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  mmu_bus_arb #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_fc_i(fc[0]), .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]),
    .m0_sel_i(sel[0]), .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_dat_o(rdat0),
    .m0_ack_o(ack0), .m0_err_o(err0), .m0_vpa_o(vpa0),
    .m1_fc_i(fc[1]), .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]),
    .m1_sel_i(sel[1]), .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_dat_o(rdat1),
    .m1_ack_o(ack1), .m1_err_o(err1), .m1_vpa_o(vpa1),
    .s_fc_o(s_fc_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_vpa_i(s_vpa_i),
    .gnt_o(gnt_o)
  );

  // Reference model: owner is -1 (nobody), 0 or 1.
  int mg;
  int mlast;
  int mwd;

  function automatic bit model_fire();
`ifdef MMU_ARB_WATCHDOG_EN
    return (mg >= 0) && (mwd == TIMEOUT);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    mg = -1; mlast = 1; mwd = 0;
  endtask

  // Apply the arbitration rules to the inputs present before the clock edge.
  task automatic model_advance();
    int ng;
    bit stalled;
    if (mg >= 0 && cyc[mg]) ng = mg;
    else if (mg >= 0) ng = cyc[1 - mg] ? 1 - mg : -1;
    else if (cyc[0] && cyc[1]) ng = 1 - mlast;
    else if (cyc[0]) ng = 0;
    else if (cyc[1]) ng = 1;
    else ng = -1;
    stalled = (mg >= 0) && stb[mg] && !s_ack_i && !s_err_i && !model_fire();
    mwd = stalled ? mwd + 1 : 0;
    if (ng >= 0 && ng != mg) mlast = ng;
    mg = ng;
  endtask

  task automatic chk(string name, logic [79:0] act, logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(string tag);
    logic [1:0]  eg;
    logic [79:0] es, as_;
    logic [5:0]  er;
    bit          f;
    eg = (mg == 0) ? 2'b01 : (mg == 1) ? 2'b10 : 2'b00;
    es = '0;
    if (mg >= 0) es = {6'd0, fc[mg], cyc[mg], stb[mg], we[mg], sel[mg], adr[mg], wdat[mg]};
    as_ = {6'd0, s_fc_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o};
    f = model_fire();
    er = {mg == 0 && s_ack_i, mg == 0 && (s_err_i || f), mg == 0 && s_vpa_i,
          mg == 1 && s_ack_i, mg == 1 && (s_err_i || f), mg == 1 && s_vpa_i};
    chk({tag, " gnt"}, 80'(gnt_o), 80'(eg));
    chk({tag, " slave"}, as_, es);
    chk({tag, " resp"}, 80'({ack0, err0, vpa0, ack1, err1, vpa1}), 80'(er));
    chk({tag, " rdata"}, {16'd0, rdat0, rdat1}, {16'd0, s_dat_i, s_dat_i});
  endtask

  task automatic step();
    model_advance();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    cyc = 2'b00; stb = 2'b00; we = 2'b00;
    s_ack_i = 1'b0; s_err_i = 1'b0; s_vpa_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic c0, s0, c1, s1, ack, err;
    logic [1:0] gnt;
    logic a0, a1, e0, e1;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [31:0] exp_adr;
    logic        exp_cyc;
    int          granted_at;

    fc[0] = 3'd5; fc[1] = 3'd1; sel[0] = 4'hf; sel[1] = 4'h3;
    adr[0] = 32'h0000_1000; adr[1] = 32'h0000_2000;
    wdat[0] = 32'hdead_0000; wdat[1] = 32'h0000_beef;
    s_dat_i = 32'h1234_5678;
    model_reset();
    do_reset();

    #4;
    check_all("reset");
    chk("reset gnt00", 80'(gnt_o), 80'd0);

    //            c0 s0 c1 s1 ack err  gnt    a0 a1 e0 e1
    tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 2'b01, 1'b0,1'b0,1'b0,1'b0};
    tbl[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b0, 2'b01, 1'b1,1'b0,1'b0,1'b0};
    tbl[4]  = '{1'b1,1'b1,1'b1,1'b0,1'b1,1'b0, 2'b01, 1'b1,1'b0,1'b0,1'b0};
    tbl[5]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 2'b01, 1'b0,1'b0,1'b0,1'b0};
    tbl[6]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b1, 2'b10, 1'b0,1'b0,1'b0,1'b1};
    tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b10, 1'b0,1'b0,1'b0,1'b0};
    tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0,1'b0,1'b0};
    tbl[9]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0,1'b0,1'b0};
    tbl[10] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 2'b01, 1'b0,1'b0,1'b0,1'b0};
    tbl[11] = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0, 2'b01, 1'b1,1'b0,1'b0,1'b0};

    for (int i = 0; i < 12; i++) begin
      cyc = {tbl[i].c1, tbl[i].c0};
      stb = {tbl[i].s1, tbl[i].s0};
      s_ack_i = tbl[i].ack;
      s_err_i = tbl[i].err;
      #4;
      exp_adr = tbl[i].gnt[0] ? adr[0] : tbl[i].gnt[1] ? adr[1] : 32'd0;
      exp_cyc = tbl[i].gnt[0] ? tbl[i].c0 : tbl[i].gnt[1] ? tbl[i].c1 : 1'b0;
      chk($sformatf("vec%0d gnt", i), 80'(gnt_o), 80'(tbl[i].gnt));
      chk($sformatf("vec%0d ack", i), 80'({ack0, ack1}), 80'({tbl[i].a0, tbl[i].a1}));
      chk($sformatf("vec%0d err", i), 80'({err0, err1}), 80'({tbl[i].e0, tbl[i].e1}));
      chk($sformatf("vec%0d s_adr", i), 80'(s_adr_o), 80'(exp_adr));
      chk($sformatf("vec%0d s_cyc", i), 80'(s_cyc_o), 80'(exp_cyc));
      step();
    end

    // Simultaneous request after reset, then a locked RMW by master 0.
    do_reset();
    cyc = 2'b11; stb = 2'b11;
    #4;
    step();
    chk("first contention gnt", 80'(gnt_o), 80'(2'b01));
    for (int i = 0; i < 6; i++) begin
      stb[0]  = (i != 2 && i != 5);
      we[0]   = (i >= 3);
      s_ack_i = (i == 1 || i == 4);
      #4;
      chk($sformatf("rmw%0d gnt", i), 80'(gnt_o), 80'(2'b01));
      chk($sformatf("rmw%0d m1_ack", i), 80'(ack1), 80'd0);
      chk($sformatf("rmw%0d m0_ack", i), 80'(ack0), 80'(s_ack_i));
      step();
    end
    cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0; s_ack_i = 1'b0;
    #4;
    check_all("rmw release");
    step();
    chk("rmw handover gnt", 80'(gnt_o), 80'(2'b10));
    cyc = 2'b00; stb = 2'b00;
    #4;
    step();

    // Stalled strobe: watchdog error exactly once, TIMEOUT cycles after grant.
    do_reset();
    cyc = 2'b01; stb = 2'b01;
    #4;
    step();
    granted_at = 0;
`ifdef MMU_ARB_WATCHDOG_EN
    for (int i = 0; i < 8; i++) begin
      #4;
      chk($sformatf("wd%0d m0_err", i), 80'(err0), 80'(i == TIMEOUT));
      chk($sformatf("wd%0d m1_err", i), 80'(err1), 80'd0);
      if (err0) granted_at++;
      step();
    end
    chk("wd error count", 80'(granted_at), 80'd1);
`else
    for (int i = 0; i < 20; i++) begin
      #4;
      chk($sformatf("wd%0d m0_err", i), 80'(err0), 80'd0);
      step();
    end
`endif
    cyc = 2'b00; stb = 2'b00;
    #4;
    step();

    // Asynchronous reset in the middle of a master 1 cycle.
    do_reset();
    cyc = 2'b10; stb = 2'b10;
    #4;
    step();
    #4;
    step();
    chk("pre-reset gnt", 80'(gnt_o), 80'(2'b10));
    s_ack_i = 1'b1;
    #4;
    chk("pre-reset m1_ack", 80'(ack1), 80'd1);
    rst_ni = 1'b0;
    #1;
    chk("async rst s_cyc", 80'(s_cyc_o), 80'd0);
    chk("async rst gnt", 80'(gnt_o), 80'd0);
    chk("async rst m1_ack", 80'(ack1), 80'd0);
    chk("async rst rdata", 80'(rdat1), 80'(s_dat_i));
    do_reset();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (cyc[m]) cyc[m] = ($urandom_range(0, 5) != 0);
        else        cyc[m] = ($urandom_range(0, 2) == 0);
        stb[m]  = $urandom_range(0, 1);
        we[m]   = $urandom_range(0, 1);
        fc[m]   = 3'($urandom);
        sel[m]  = 4'($urandom);
        adr[m]  = $urandom;
        wdat[m] = $urandom;
      end
      s_ack_i = ($urandom_range(0, 3) == 0);
      s_err_i = ($urandom_range(0, 9) == 0);
      s_vpa_i = $urandom_range(0, 1);
      s_dat_i = $urandom;
      #4;
      check_all($sformatf("rnd%0d", n));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
